// File: rtl/fetch_stage_v.sv
// rtl/fetch_stage_v.sv - instruction fetch stage: PC, ROM addressing, valid/ready to decode
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds sticky fetch_misaligned output and freeze).
module fetch_stage_v #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ROM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              fetch_misaligned
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_v_q, if_v_d;

    logic        redir_take;
    logic [31:0] redir_tgt;
    logic        advance;
    logic [31:0] issue_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misal_q, misal_d;
    logic        redir_bad;

    // Once frozen, redirects are ignored; the target keeps its low bits so they can be checked.
    assign redir_take       = redirect_valid & ~misal_q;
    assign redir_tgt        = redirect_pc;
    assign redir_bad        = redir_take & (redirect_pc[1:0] != 2'b00);
    assign fetch_misaligned = misal_q;
`else
    logic        unused_pc_lsbs;

    // Low bits of the target are dropped so the PC is always word aligned.
    assign redir_take     = redirect_valid;
    assign redir_tgt      = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc[1:0];
`endif

    // Issue a new fetch unless a presented word is stalled; a stalled word is simply re-read.
    always_comb begin
        advance   = ~if_v_q | out_ready | redir_take;
        issue_pc  = redir_take ? redir_tgt : pc_q;
        rom_addr  = advance ? issue_pc[ROM_AW+1:2] : if_pc_q[ROM_AW+1:2];
        out_valid = if_v_q & ~redir_take;
        out_pc    = if_pc_q;
        out_instr = rom_instr;
    end

    // Next-state: advance moves the issued PC into the in-flight slot, otherwise everything holds.
    always_comb begin
        pc_d    = pc_q;
        if_pc_d = if_pc_q;
        if_v_d  = if_v_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        misal_d = misal_q;
        if (misal_q) begin
            if_v_d = 1'b0;
        end else if (redir_bad) begin
            misal_d = 1'b1;
            if_v_d  = 1'b0;
        end else if (advance) begin
            if_v_d  = 1'b1;
            if_pc_d = issue_pc;
            pc_d    = issue_pc + 32'd4;
        end
`else
        if (advance) begin
            if_v_d  = 1'b1;
            if_pc_d = issue_pc;
            pc_d    = issue_pc + 32'd4;
        end
`endif
    end

    // State registers with asynchronous clear so out_valid drops the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            if_pc_q <= 32'h0000_0000;
            if_v_q  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misal_q <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            if_pc_q <= if_pc_d;
            if_v_q  <= if_v_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misal_q <= misal_d;
`endif
        end
    end

endmodule
